// File: rtl/rect_calc.sv
// Rectangle calculator: captures two side lengths from independent /dav-rfd producers and returns
// either the perimeter (one cycle) or the area (W-cycle shift-and-add) over a /dav-rfd handshake.
module rect_calc #(
    parameter int unsigned W = 8
) (
    input  logic           clock,
    input  logic           reset_,
    input  logic [W-1:0]   data_in_1,
    input  logic           dav_in_1_,
    output logic           rfd_in_1,
    input  logic [W-1:0]   data_in_2,
    input  logic           dav_in_2_,
    output logic           rfd_in_2,
    input  logic           mode,
    output logic [2*W-1:0] data_out,
    output logic           dav_out_,
    input  logic           rfd_out
);

    localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {StWait, StCalc, StOut, StDone} state_e;

    state_e           state_q, state_d;
    logic [W-1:0]     x1_q, x1_d, x2_q, x2_d;
    logic [2*W-1:0]   acc_q, acc_d, mul_q, mul_d, dout_q, dout_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             rfd1_q, rfd1_d, rfd2_q, rfd2_d;
    logic             dav_q, dav_d;

    logic             cap1, cap2;
    logic [W-1:0]     x1_eff;
    logic [W+1:0]     perim;
    logic [2*W-1:0]   acc_sum;

    assign rfd_in_1 = rfd1_q;
    assign rfd_in_2 = rfd2_q;
    assign data_out = dout_q;
    assign dav_out_ = dav_q;

    always_comb begin
        state_d = state_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        acc_d   = acc_q;
        mul_d   = mul_q;
        dout_d  = dout_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        rfd1_d  = rfd1_q;
        rfd2_d  = rfd2_q;
        dav_d   = dav_q;

        cap1    = rfd1_q & ~dav_in_1_;
        cap2    = rfd2_q & ~dav_in_2_;
        // Operand 1 may be captured on the same edge the calculation starts.
        x1_eff  = cap1 ? data_in_1 : x1_q;
        perim   = {({1'b0, x1_q} + {1'b0, x2_q}), 1'b0};
        acc_sum = x2_q[0] ? (acc_q + mul_q) : acc_q;

        unique case (state_q)
            StWait: begin
                if (cap1) begin
                    x1_d   = data_in_1;
                    rfd1_d = 1'b0;
                end
                if (cap2) begin
                    x2_d   = data_in_2;
                    rfd2_d = 1'b0;
                end
                if ((~rfd1_q | cap1) & (~rfd2_q | cap2)) begin
                    mode_d  = mode;
                    acc_d   = '0;
                    mul_d   = {{W{1'b0}}, x1_eff};
                    cnt_d   = CntW'(W - 1);
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (!mode_q) begin
                    dout_d  = (2*W)'(perim);
                    dav_d   = 1'b0;
                    state_d = StOut;
                end else begin
                    acc_d = acc_sum;
                    mul_d = mul_q << 1;
                    x2_d  = x2_q >> 1;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        dout_d  = acc_sum;
                        dav_d   = 1'b0;
                        state_d = StOut;
                    end
                end
            end
            StOut: begin
                if (!rfd_out) begin
                    dav_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                // Producers must release dav_ first so a held strobe is not captured twice.
                if (rfd_out & dav_in_1_ & dav_in_2_) begin
                    rfd1_d  = 1'b1;
                    rfd2_d  = 1'b1;
                    state_d = StWait;
                end
            end
            default: state_d = StWait;
        endcase
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q <= StWait;
            x1_q    <= '0;
            x2_q    <= '0;
            acc_q   <= '0;
            mul_q   <= '0;
            dout_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            rfd1_q  <= 1'b1;
            rfd2_q  <= 1'b1;
            dav_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            acc_q   <= acc_d;
            mul_q   <= mul_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            rfd1_q  <= rfd1_d;
            rfd2_q  <= rfd2_d;
            dav_q   <= dav_d;
        end
    end

endmodule

// File: tb/tb_rect_calc.sv
// Scoreboard bench for rect_calc: directed operations push expected results, a monitor checks
// each result as dav_out_ falls.
module tb_rect_calc;

    localparam int W = 8;

    logic           clock = 1'b0;
    logic           reset_;
    logic [W-1:0]   data_in_1, data_in_2;
    logic           dav_in_1_, dav_in_2_;
    logic           rfd_in_1, rfd_in_2;
    logic           mode;
    logic [2*W-1:0] data_out;
    logic           dav_out_;
    logic           rfd_out;

    int             n_vec = 0;
    int             n_err = 0;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] exp_v;
    logic           dav_prev = 1'b1;

    rect_calc #(.W(W)) dut (
        .clock    (clock),
        .reset_   (reset_),
        .data_in_1(data_in_1),
        .dav_in_1_(dav_in_1_),
        .rfd_in_1 (rfd_in_1),
        .data_in_2(data_in_2),
        .dav_in_2_(dav_in_2_),
        .rfd_in_2 (rfd_in_2),
        .mode     (mode),
        .data_out (data_out),
        .dav_out_ (dav_out_),
        .rfd_out  (rfd_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: every falling edge of dav_out_ consumes one scoreboard entry.
    always @(negedge clock) begin
        if (reset_ && dav_prev && !dav_out_) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result: got %0d, expected no result", data_out);
            end else begin
                exp_v = exp_q.pop_front();
                check("result", 32'(data_out), 32'(exp_v));
            end
        end
        dav_prev = dav_out_;
    end

    // Both producers strobe together; returns #1 after the capture edge.
    task automatic present(input logic [W-1:0] x, input logic [W-1:0] y, input logic m,
                           input logic [2*W-1:0] expect_res);
        @(posedge clock); #1;
        data_in_1 = x; data_in_2 = y; mode = m;
        dav_in_1_ = 1'b0; dav_in_2_ = 1'b0;
        exp_q.push_back(expect_res);
        @(posedge clock); #1;
        check("rfd_in_1_after_capture", 32'(rfd_in_1), 0);
        check("rfd_in_2_after_capture", 32'(rfd_in_2), 0);
        dav_in_1_ = 1'b1; dav_in_2_ = 1'b1;
    endtask

    // Counts edges from the capture edge until dav_out_ is low.
    task automatic wait_result(input string name, input int lat, input logic toggle_mode);
        int n = 0;
        do begin
            if (toggle_mode) mode = ~mode;
            @(posedge clock); #1;
            n++;
        end while (dav_out_ && n < 40);
        check(name, 32'(n), 32'(lat));
    endtask

    task automatic consume();
        rfd_out = 1'b0;
        @(posedge clock); #1;
        check("dav_out_released", 32'(dav_out_), 1);
        rfd_out = 1'b1;
        @(posedge clock); #1;
        check("rfd_in_1_rearmed", 32'(rfd_in_1), 1);
        check("rfd_in_2_rearmed", 32'(rfd_in_2), 1);
    endtask

    initial begin
        reset_ = 1'b0; data_in_1 = '0; data_in_2 = '0;
        dav_in_1_ = 1'b1; dav_in_2_ = 1'b1; mode = 1'b0; rfd_out = 1'b1;
        #12;
        check("reset_rfd_in_1", 32'(rfd_in_1), 1);
        check("reset_rfd_in_2", 32'(rfd_in_2), 1);
        check("reset_dav_out_", 32'(dav_out_), 1);
        check("reset_data_out", 32'(data_out), 0);
        reset_ = 1'b1;

        // Perimeter of 3x5
        present(8'd3, 8'd5, 1'b0, 16'd16);
        wait_result("latency_perim_3_5", 1, 1'b0);
        consume();

        // Full-scale operands
        present(8'd255, 8'd255, 1'b1, 16'd65025);
        wait_result("latency_area_255", 8, 1'b0);
        consume();
        present(8'd255, 8'd255, 1'b0, 16'd1020);
        wait_result("latency_perim_255", 1, 1'b0);
        consume();

        // Staggered producers; stray second strobe on producer 1 must be ignored
        @(posedge clock); #1;
        data_in_1 = 8'd7; dav_in_1_ = 1'b0; mode = 1'b0;
        @(posedge clock); #1;
        check("rfd_in_1_held_low", 32'(rfd_in_1), 0);
        check("rfd_in_2_still_ready", 32'(rfd_in_2), 1);
        dav_in_1_ = 1'b1;
        repeat (3) @(posedge clock);
        #1; data_in_1 = 8'd99; dav_in_1_ = 1'b0;
        @(posedge clock); #1;
        dav_in_1_ = 1'b1;
        check("rfd_in_1_ignores_pulse", 32'(rfd_in_1), 0);
        repeat (4) @(posedge clock);
        #1;
        data_in_2 = 8'd9; dav_in_2_ = 1'b0; mode = 1'b1;
        exp_q.push_back(16'd63);
        @(posedge clock); #1;
        check("rfd_in_2_captured", 32'(rfd_in_2), 0);
        dav_in_2_ = 1'b1;
        wait_result("latency_area_staggered", 8, 1'b1);
        consume();

        // Zero operand, then check no stale accumulator leaks into the next result
        present(8'd0, 8'd200, 1'b1, 16'd0);
        wait_result("latency_area_zero", 8, 1'b0);
        consume();
        present(8'd1, 8'd1, 1'b0, 16'd4);
        wait_result("latency_perim_1_1", 1, 1'b0);
        consume();

        // Consumer already not ready; producer 2 holds dav_ low past the result
        rfd_out = 1'b0;
        @(posedge clock); #1;
        data_in_1 = 8'd4; data_in_2 = 8'd6; mode = 1'b0;
        dav_in_1_ = 1'b0; dav_in_2_ = 1'b0;
        exp_q.push_back(16'd20);
        @(posedge clock); #1;
        dav_in_1_ = 1'b1;
        wait_result("latency_perim_stall", 1, 1'b0);
        @(posedge clock); #1;
        check("dav_out_one_cycle", 32'(dav_out_), 1);
        rfd_out = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            check("stall_rfd_in_1", 32'(rfd_in_1), 0);
            check("stall_rfd_in_2", 32'(rfd_in_2), 0);
        end
        dav_in_2_ = 1'b1;
        @(posedge clock); #1;
        check("stall_release_rfd_in_1", 32'(rfd_in_1), 1);
        check("stall_release_rfd_in_2", 32'(rfd_in_2), 1);

        // Asynchronous reset during an area calculation
        present(8'd10, 8'd13, 1'b1, 16'd130);
        repeat (3) @(posedge clock);
        #2; reset_ = 1'b0;
        #1;
        check("async_reset_rfd_in_1", 32'(rfd_in_1), 1);
        check("async_reset_rfd_in_2", 32'(rfd_in_2), 1);
        check("async_reset_dav_out_", 32'(dav_out_), 1);
        check("async_reset_data_out", 32'(data_out), 0);
        exp_q.delete();
        #1; reset_ = 1'b1;
        present(8'd2, 8'd3, 1'b1, 16'd6);
        wait_result("latency_area_after_reset", 8, 1'b0);
        consume();

        repeat (2) @(posedge clock);
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
